alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sequencer directly upstream of the 8-bit ALU: accepts an operation command (op, A, B) over a valid/ready handshake.
//  Registers the operands, drives ALU In1/In2/ALU_Sel, waits a fixed settle time, then captures ALU_Result and NZVC.
//  Holds the captured result in an output register and keeps a persistent condition-code register (CCR).
//  Downstream result consumers (register file write-back, branch logic) read res_* and ccr.
// PARAMETERS
//  WIDTH          8      data width of operands/result
//  OP_W           3      opcode width (matches ALU_Sel)
//  SETTLE_CYCLES  1      cycles ALU inputs are held stable before capture (1..15)
//  OP_LEGAL_MASK  8'h01  bit n set = opcode n implemented by the ALU (default: ADD only)
// PORTS
//  clock      in   1        single clock, rising edge
//  reset      in   1        asynchronous, active-low
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        sequencer can accept command
//  cmd_op     in   OP_W     ALU operation
//  cmd_a      in   WIDTH    operand A
//  cmd_b      in   WIDTH    operand B
//  alu_in1    out  WIDTH    to ALU In1
//  alu_in2    out  WIDTH    to ALU In2
//  alu_sel    out  OP_W     to ALU ALU_Sel
//  alu_result in   WIDTH    from ALU ALU_Result
//  alu_nzvc   in   4        from ALU NZVC {N,Z,V,C}
//  res_valid  out  1        result register holds unconsumed result
//  res_ready  in   1        consumer accepts result
//  res_data   out  WIDTH    captured result
//  res_err    out  1        result belongs to an illegal opcode
//  ccr        out  4        condition codes {N,Z,V,C} of last legal op
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE; cmd_ready=0 while reset is asserted; res_valid=0, res_data=0, res_err=0, ccr=4'b0000.
//    alu_in1=0, alu_in2=0, alu_sel=0. Settle counter=0. An in-flight command is dropped, with no partial result.
//  FSM: IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/a/b and go to EXEC. Counter loads SETTLE_CYCLES-1.
//   EXEC: cmd_ready=0. alu_in1/in2/sel driven from the latched registers and stable for every EXEC cycle.
//     Counter decrements each cycle. On the cycle counter==0, capture and go to DONE.
//     Capture: res_data<=alu_result, ccr<=alu_nzvc.
//   Illegal op (OP_LEGAL_MASK[op]==0): EXEC is skipped; IDLE goes straight to DONE.
//     ALU inputs are not updated. res_data<=0, res_err<=1, ccr is unchanged.
//   DONE: res_valid=1. res_data and res_err are stable until the cycle with res_valid&res_ready, then the FSM goes to IDLE.
//  Latency: res_valid rises SETTLE_CYCLES+1 cycles after the accept edge (legal op), or 1 cycle after it (illegal op).
//  No bypass: cmd_ready is 0 in DONE even when res_ready=1. The next accept is possible at the earliest in the cycle after the handshake.
//  Peak throughput: one op every SETTLE_CYCLES+2 cycles.
//  res_err clears when the next legal result is captured. ccr persists across idle and across illegal ops.
//  alu_* outputs keep their last value outside EXEC (no toggling while idle).
//  Arithmetic: none internal. The captured result and flags are exactly the ALU's values, with no width extension.
// CONFIGURATION
//  ALU_SEQ_ACCUM_EN defined:
//    Adds input port cmd_use_acc (1 bit).
//    When cmd_use_acc=1 at accept, operand A is the current res_data instead of cmd_a. This gives accumulator chaining.
//    The value used is the last captured result, or 0 after reset.
//  ALU_SEQ_ACCUM_EN undefined:
//    Port cmd_use_acc is absent. Operand A is always cmd_a.
// TESTING
//  ADD 0x7F+0x01, res_ready=1 -> res_data=0x80, ccr=4'b1010, res_valid exactly 2 cycles after accept (SETTLE_CYCLES=1).
//  ADD 0xFF+0x01 -> res_data=0x00, ccr=4'b0101. Then ADD 0x03+0x04 -> res_data=0x07, ccr=4'b0000.
//  Backpressure: res_ready=0 for 5 cycles after result.
//    -> res_valid, res_data and cmd_ready=0 stay stable.
//    -> The next cmd is accepted only in the cycle after res_ready=1.
//  Illegal op 3'b101 after a legal op with ccr=4'b0101 -> res_err=1, res_data=0, ccr stays 4'b0101, res_valid 1 cycle after accept.
//  reset=0 asserted mid-EXEC with SETTLE_CYCLES=4 -> outputs reset immediately.
//    -> After release, no res_valid appears for the dropped cmd, and cmd_ready=1.
//  ALU_SEQ_ACCUM_EN: ADD 0x10+0x20 -> 0x30. Then ADD cmd_use_acc=1 with b=0x05 -> res_data=0x35.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Handshake and ALU-facing bus of alu_op_sequencer.
// The slave modport is the sequencer's view; master is the environment's
// view (command source, ALU and result consumer).
// ALU_SEQ_ACCUM_EN adds the cmd_use_acc command bit.
interface alu_op_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
`ifdef ALU_SEQ_ACCUM_EN
  logic             cmd_use_acc;
`endif
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [OP_W-1:0]  alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_nzvc;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic [3:0]       ccr;

`ifdef ALU_SEQ_ACCUM_EN
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, alu_nzvc, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, ccr
  );
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, alu_nzvc, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, ccr
  );
`else
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_nzvc, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, ccr
  );
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_nzvc, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_sel, res_valid, res_data, res_err, ccr
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts (op, A, B) commands, drives the external ALU,
// waits SETTLE_CYCLES, captures result and NZVC into output registers.
// Illegal opcodes bypass the ALU and return res_err=1 with res_data=0.
// Optional feature macro ALU_SEQ_ACCUM_EN: cmd_use_acc selects res_data as
// operand A (accumulator chaining).
module alu_op_sequencer #(
  parameter int                       WIDTH         = 8,
  parameter int                       OP_W          = 3,
  parameter int                       SETTLE_CYCLES = 1,
  parameter logic [(2**OP_W)-1:0]     OP_LEGAL_MASK = 'h01
) (
  input  logic                clock,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [OP_W-1:0]  alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_err_q, res_err_d;
  logic [3:0]       ccr_q, ccr_d;

  logic             cmd_ready;
  logic             cmd_fire;
  logic             op_legal;
  logic [WIDTH-1:0] operand_a;

  // cmd_ready is forced low combinationally while reset is held
  assign cmd_ready = (state_q == IDLE) && reset;
  assign cmd_fire  = bus.cmd_valid && cmd_ready;
  assign op_legal  = OP_LEGAL_MASK[bus.cmd_op];

  // Select operand A: command value or the held result for chaining
  always_comb begin
    operand_a = bus.cmd_a;
`ifdef ALU_SEQ_ACCUM_EN
    if (bus.cmd_use_acc) operand_a = res_data_q;
`endif
  end

  // Next-state and datapath register updates for IDLE -> EXEC -> DONE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_in1_d  = alu_in1_q;
    alu_in2_d  = alu_in2_q;
    alu_sel_d  = alu_sel_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    ccr_d      = ccr_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          if (op_legal) begin
            // ALU inputs only change here, so they are stable through EXEC
            alu_in1_d = operand_a;
            alu_in2_d = bus.cmd_b;
            alu_sel_d = bus.cmd_op;
            cnt_d     = 4'(SETTLE_CYCLES - 1);
            state_d   = EXEC;
          end else begin
            // Illegal op never reaches the ALU; ccr is left untouched
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = DONE;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          res_data_d = bus.alu_result;
          ccr_d      = bus.alu_nzvc;
          res_err_d  = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      alu_in1_q  <= '0;
      alu_in2_q  <= '0;
      alu_sel_q  <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      ccr_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_in1_q  <= alu_in1_d;
      alu_in2_q  <= alu_in2_d;
      alu_sel_q  <= alu_sel_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      ccr_q      <= ccr_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign bus.ccr       = ccr_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: scoreboard queue filled by the driver,
// drained by a monitor on result handshakes. A second instance with
// SETTLE_CYCLES=4 covers the mid-EXEC asynchronous reset.
module tb_alu_op_sequencer;

  logic clock = 1'b0;
  logic rst_n;
  logic rst4_n;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic rv_prev = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic [3:0] ccr;
    int         lat;
  } exp_t;
  exp_t sbq[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  alu_op_sequencer_if #(.WIDTH(8), .OP_W(3)) bus ();
  alu_op_sequencer_if #(.WIDTH(8), .OP_W(3)) bus4 ();

  alu_op_sequencer #(.WIDTH(8), .OP_W(3), .SETTLE_CYCLES(1), .OP_LEGAL_MASK(8'h01)) dut (
    .clock(clock), .reset(rst_n), .bus(bus.slave));
  alu_op_sequencer #(.WIDTH(8), .OP_W(3), .SETTLE_CYCLES(4), .OP_LEGAL_MASK(8'h01)) dut4 (
    .clock(clock), .reset(rst4_n), .bus(bus4.slave));

  // Reference ALU: ADD only; other selects return a marker value
  function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] sel);
    logic [8:0] s;
    logic n, z, v, c;
    s = {1'b0, a} + {1'b0, b};
    n = s[7];
    z = (s[7:0] == 8'h00);
    v = (a[7] == b[7]) && (s[7] != a[7]);
    c = s[8];
    if (sel == 3'd0) return {n, z, v, c, s[7:0]};
    return {4'hF, 8'hEE};
  endfunction

  always_comb {bus.alu_nzvc, bus.alu_result}   = alu_ref(bus.alu_in1, bus.alu_in2, bus.alu_sel);
  always_comb {bus4.alu_nzvc, bus4.alu_result} = alu_ref(bus4.alu_in1, bus4.alu_in2, bus4.alu_sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on res_valid rise, payload on handshake
  always @(negedge clock) begin
    if (rst_n) begin
      if (bus.res_valid && !rv_prev) begin
        if (sbq.size() == 0) check("unexpected_res_valid", bus.res_valid, 1'b0);
        else                 check("latency", cyc - last_acc_cyc, sbq[0].lat);
      end
      if (bus.res_valid && bus.res_ready && sbq.size() > 0) begin
        check("res_data", bus.res_data, sbq[0].data);
        check("res_err", bus.res_err, sbq[0].err);
        check("ccr", bus.ccr, sbq[0].ccr);
        void'(sbq.pop_front());
      end
    end
    rv_prev <= bus.res_valid;
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic acc, input logic [7:0] edata, input logic eerr,
                      input logic [3:0] eccr, input int elat);
    bit accepted = 1'b0;
    sbq.push_back('{edata, eerr, eccr, elat});
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
`ifdef ALU_SEQ_ACCUM_EN
    bus.cmd_use_acc = acc;
`else
    if (acc) $display("note: accumulator request ignored in this build");
`endif
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.cmd_ready) begin
        last_acc_cyc = cyc;
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) check("accept_timeout", bus.cmd_ready, 1'b1);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 8'h5A;
    bus.cmd_b     = 8'hA5;
    bus.cmd_op    = 3'd7;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clock);
    check("drain_timeout", sbq.size(), 0);
    @(negedge clock);
  endtask

  initial begin
    int hs_cyc;
    int acc4;
    bit seen;
    rst_n = 1'b0;
    rst4_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.res_ready = 1'b1;
    bus4.cmd_valid = 1'b0; bus4.cmd_op = '0; bus4.cmd_a = '0; bus4.cmd_b = '0; bus4.res_ready = 1'b1;
`ifdef ALU_SEQ_ACCUM_EN
    bus.cmd_use_acc = 1'b0;
    bus4.cmd_use_acc = 1'b0;
`endif
    #12;
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_data", bus.res_data, 8'h00);
    check("rst_res_err", bus.res_err, 1'b0);
    check("rst_ccr", bus.ccr, 4'b0000);
    check("rst_alu_in1", bus.alu_in1, 8'h00);
    check("rst_alu_in2", bus.alu_in2, 8'h00);
    check("rst_alu_sel", bus.alu_sel, 3'd0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    rst4_n = 1'b1;
    @(negedge clock);
    check("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // Overflow into sign bit, then carry-out to zero
    send(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 4'b1010, 2);
    wait_drain();
    send(3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 4'b0101, 2);
    wait_drain();
    // Illegal op: error flag, zero data, ccr and ALU inputs untouched
    send(3'd5, 8'h12, 8'h34, 1'b0, 8'h00, 1'b1, 4'b0101, 1);
    wait_drain();
    check("illegal_alu_in1_held", bus.alu_in1, 8'hFF);
    check("illegal_alu_in2_held", bus.alu_in2, 8'h01);
    check("illegal_alu_sel_held", bus.alu_sel, 3'd0);
    send(3'd0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 4'b0000, 2);
    wait_drain();

    // Backpressure with the next command already waiting
    bus.res_ready = 1'b0;
    send(3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 4'b0000, 2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    check("bp_res_valid_seen", seen, 1'b1);
    @(posedge clock); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_a = 8'h01; bus.cmd_b = 8'h01;
    sbq.push_back('{8'h02, 1'b0, 4'b0000, 2});
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_res_valid", bus.res_valid, 1'b1);
      check("bp_res_data", bus.res_data, 8'h30);
      check("bp_cmd_ready", bus.cmd_ready, 1'b0);
    end
    @(posedge clock); #1;
    bus.res_ready = 1'b1;
    @(negedge clock);
    hs_cyc = cyc;
    check("bp_hs_cmd_ready", bus.cmd_ready, 1'b0);
    @(negedge clock);
    check("bp_accept_next_cycle", bus.cmd_ready, 1'b1);
    check("bp_accept_cycle", cyc - hs_cyc, 1);
    last_acc_cyc = cyc;
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
    wait_drain();

`ifdef ALU_SEQ_ACCUM_EN
    send(3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 4'b0000, 2);
    wait_drain();
    send(3'd0, 8'hAA, 8'h05, 1'b1, 8'h35, 1'b0, 4'b0000, 2);
    wait_drain();
`endif

    // SETTLE_CYCLES=4 instance: full op, then reset during EXEC
    @(posedge clock); #1;
    bus4.cmd_valid = 1'b1; bus4.cmd_op = 3'd0; bus4.cmd_a = 8'h7F; bus4.cmd_b = 8'h01;
    acc4 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus4.cmd_ready) begin acc4 = cyc; break; end
    end
    check("s4_accept", bus4.cmd_ready, 1'b1);
    @(posedge clock); #1;
    bus4.cmd_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus4.res_valid) begin seen = 1'b1; break; end
    end
    check("s4_res_valid_seen", seen, 1'b1);
    check("s4_latency", cyc - acc4, 5);
    check("s4_res_data", bus4.res_data, 8'h80);
    check("s4_ccr", bus4.ccr, 4'b1010);
    @(posedge clock); #1;
    bus4.cmd_valid = 1'b1; bus4.cmd_a = 8'h01; bus4.cmd_b = 8'h02;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus4.cmd_ready) break;
    end
    @(posedge clock); #1;
    bus4.cmd_valid = 1'b0;
    @(posedge clock); #2;
    check("s4_exec_alu_in1", bus4.alu_in1, 8'h01);
    rst4_n = 1'b0;
    #1;
    check("s4_rst_res_valid", bus4.res_valid, 1'b0);
    check("s4_rst_res_data", bus4.res_data, 8'h00);
    check("s4_rst_ccr", bus4.ccr, 4'b0000);
    check("s4_rst_cmd_ready", bus4.cmd_ready, 1'b0);
    check("s4_rst_alu_in1", bus4.alu_in1, 8'h00);
    @(posedge clock); #1;
    rst4_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus4.res_valid) seen = 1'b1;
    end
    check("s4_no_dropped_result", seen, 1'b0);
    check("s4_post_rst_cmd_ready", bus4.cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
